// File: rtl/axis_tx_arbiter.sv
// Frame-locked round-robin arbiter that merges NUM_PORTS AXI-Stream sources onto one MAC TX stream.
// Optional inter-frame gap is enabled with `AXIS_TX_ARB_IFG_EN; the data path is combinational in XFER.
module axis_tx_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int IFG_CYCLES = 3,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int GW         = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_trdy,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_trdy,
  output logic [GW-1:0]                    grant_id,
  output logic                             grant_active
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_next_ptr;
  logic            w_xfer;
  logic            w_last_hs;

  // First requester at or after ptr, wrapping; lowest offset wins because it is written last.
  function automatic logic [GW-1:0] f_pick(input logic [NUM_PORTS-1:0] req,
                                           input logic [GW-1:0] ptr);
    logic [GW:0] cand;
    f_pick = ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_PORTS)) cand = cand - (GW+1)'(NUM_PORTS);
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cand == (GW+1)'(p) && req[p]) f_pick = cand[GW-1:0];
      end
    end
  endfunction

  assign w_pick     = f_pick(s_axis_tvalid, r_rr_ptr);
  assign w_next_ptr = (r_grant_id == GW'(NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_xfer     = (r_state == S_XFER);
  assign w_last_hs  = m_axis_tvalid & m_axis_trdy & m_axis_tlast;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_trdy   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_xfer && r_grant_id == GW'(p)) begin
        m_axis_tdata   = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep   = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tvalid  = s_axis_tvalid[p];
        m_axis_tlast   = s_axis_tlast[p];
        s_axis_trdy[p] = m_axis_trdy;
      end
    end
  end

  assign grant_id     = r_grant_id;
  assign grant_active = w_xfer;

`ifdef AXIS_TX_ARB_IFG_EN
  logic [3:0] r_gap_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|s_axis_tvalid) begin
            r_grant_id <= w_pick;
            r_state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_last_hs) begin
            r_rr_ptr  <= w_next_ptr;
            r_gap_cnt <= 4'(IFG_CYCLES - 1);
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) r_state <= S_IDLE;
          else                   r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  logic w_unused_ifg;
  assign w_unused_ifg = (IFG_CYCLES > 0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|s_axis_tvalid) begin
            r_grant_id <= w_pick;
            r_state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_last_hs) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench: cycle table on a 2-port arbiter plus a 4-port wrap-around sequence.
module tb_axis_tx_arbiter;

`ifdef AXIS_TX_ARB_IFG_EN
  localparam int GAP_N = 3;
`else
  localparam int GAP_N = 0;
`endif
  localparam int G = GAP_N + 1;

  logic        clk;
  logic        reset_n;
  logic [63:0] s_tdata2;
  logic [7:0]  s_tkeep2;
  logic [1:0]  s_tvalid2, s_tlast2, s_trdy2;
  logic [31:0] m_tdata2;
  logic [3:0]  m_tkeep2;
  logic        m_tvalid2, m_tlast2, m_trdy2;
  logic        grant_id2, grant_active2;

  logic [127:0] s_tdata4;
  logic [15:0]  s_tkeep4;
  logic [3:0]   s_tvalid4, s_tlast4, s_trdy4;
  logic [31:0]  m_tdata4;
  logic [3:0]   m_tkeep4;
  logic         m_tvalid4, m_tlast4, m_trdy4;
  logic [1:0]   grant_id4;
  logic         grant_active4;

  axis_tx_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(2), .IFG_CYCLES(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata2), .s_axis_tkeep(s_tkeep2), .s_axis_tvalid(s_tvalid2),
    .s_axis_tlast(s_tlast2), .s_axis_trdy(s_trdy2),
    .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
    .m_axis_tlast(m_tlast2), .m_axis_trdy(m_trdy2),
    .grant_id(grant_id2), .grant_active(grant_active2)
  );

  axis_tx_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(4), .IFG_CYCLES(3)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata4), .s_axis_tkeep(s_tkeep4), .s_axis_tvalid(s_tvalid4),
    .s_axis_tlast(s_tlast4), .s_axis_trdy(s_trdy4),
    .m_axis_tdata(m_tdata4), .m_axis_tkeep(m_tkeep4), .m_axis_tvalid(m_tvalid4),
    .m_axis_tlast(m_tlast4), .m_axis_trdy(m_trdy4),
    .grant_id(grant_id4), .grant_active(grant_active4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  last;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        trdy;
    logic        e_vld;
    logic        e_last;
    logic [31:0] e_dat;
    logic [1:0]  e_srdy;
    logic        e_gid;
    logic        e_act;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] v, input logic [1:0] l,
                     input logic [31:0] d0, input logic [31:0] d1, input logic t,
                     input logic ev, input logic el, input logic [31:0] ed,
                     input logic [1:0] es, input logic eg, input logic ea);
    vec_t x;
    x.rst_n = r; x.vld = v; x.last = l; x.d0 = d0; x.d1 = d1; x.trdy = t;
    x.e_vld = ev; x.e_last = el; x.e_dat = ed; x.e_srdy = es; x.e_gid = eg; x.e_act = ea;
    tbl.push_back(x);
  endtask

  // Rows where the arbiter is not transferring: everything quiet, grant_id holds.
  task automatic add_idle(input int n, input logic [1:0] v, input logic [31:0] d0,
                          input logic [31:0] d1, input logic eg);
    for (int i = 0; i < n; i++) add(1'b1, v, 2'b00, d0, d1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, eg, 1'b0);
  endtask

  localparam logic [31:0] A = 32'hA000_0000, B = 32'hB000_0000, C = 32'hC000_0000;
  localparam logic [31:0] D = 32'hD000_0000, E = 32'hE000_0000, F = 32'hF000_0000;
  localparam logic [31:0] GD = 32'h6000_0000, H = 32'h7000_0000, STALL = 32'hDEAD_0000;

  int          frames;
  int          idle;
  logic [31:0] exp_keep;

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    s_tdata2 = '0; s_tkeep2 = {4'h7, 4'hF}; s_tvalid2 = 2'b11; s_tlast2 = 2'b00; m_trdy2 = 1'b1;
    s_tdata4 = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    s_tkeep4 = 16'hFFFF; s_tvalid4 = 4'hF; s_tlast4 = 4'hF; m_trdy4 = 1'b1;

    // Two-port contention: port 0 frame fully, then port 1.
    add(1, 2'b11, 2'b00, A,   B, 1, 0, 0, 32'h0, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00, A,   B, 1, 1, 0, A,     2'b01, 0, 1);
    add(1, 2'b11, 2'b00, A+1, B, 1, 1, 0, A+1,   2'b01, 0, 1);
    add(1, 2'b11, 2'b00, A+2, B, 1, 1, 0, A+2,   2'b01, 0, 1);
    add(1, 2'b11, 2'b01, A+3, B, 1, 1, 1, A+3,   2'b01, 0, 1);
    add_idle(G, 2'b10, 32'h0, B, 0);
    for (int k = 0; k < 3; k++)
      add(1, 2'b10, 2'b00, 32'h0, B+k, 1, 1, 0, B+k, 2'b10, 1, 1);
    add(1, 2'b10, 2'b10, 32'h0, B+3, 1, 1, 1, B+3, 2'b10, 1, 1);
    // Owner stall and back-pressure; port 1 keeps requesting.
    add_idle(G, 2'b11, C, D, 1);
    add(1, 2'b11, 2'b00, C,   D, 1, 1, 0, C,   2'b01, 0, 1);
    add(1, 2'b11, 2'b00, C+1, D, 0, 1, 0, C+1, 2'b00, 0, 1);
    add(1, 2'b11, 2'b00, C+1, D, 0, 1, 0, C+1, 2'b00, 0, 1);
    add(1, 2'b11, 2'b00, C+1, D, 1, 1, 0, C+1, 2'b01, 0, 1);
    for (int k = 0; k < 3; k++)
      add(1, 2'b10, 2'b00, STALL, D, 1, 0, 0, STALL, 2'b01, 0, 1);
    add(1, 2'b11, 2'b01, C+2, D, 1, 1, 1, C+2, 2'b01, 0, 1);
    add_idle(G, 2'b10, 32'h0, D, 0);
    add(1, 2'b10, 2'b10, 32'h0, D, 1, 1, 1, D, 2'b10, 1, 1);
    // Port 0 back-to-back 2-beat frames: inter-frame idle count.
    add_idle(G, 2'b01, GD, 32'h0, 1);
    add(1, 2'b01, 2'b00, GD,   32'h0, 1, 1, 0, GD,   2'b01, 0, 1);
    add(1, 2'b01, 2'b01, GD+1, 32'h0, 1, 1, 1, GD+1, 2'b01, 0, 1);
    add_idle(G, 2'b01, H, 32'h0, 0);
    add(1, 2'b01, 2'b00, H,   32'h0, 1, 1, 0, H,   2'b01, 0, 1);
    add(1, 2'b01, 2'b01, H+1, 32'h0, 1, 1, 1, H+1, 2'b01, 0, 1);
    // Reset on beat 2 of a port-1 frame; afterwards pointer is 0 again.
    add_idle(G, 2'b10, 32'h0, E, 0);
    add(1, 2'b10, 2'b00, 32'h0, E,   1, 1, 0, E,   2'b10, 1, 1);
    add(0, 2'b10, 2'b00, 32'h0, E+1, 1, 1, 0, E+1, 2'b10, 1, 1);
    add(1, 2'b11, 2'b00, F, E+2, 1, 0, 0, 32'h0, 2'b00, 0, 0);
    add(1, 2'b11, 2'b01, F, E+2, 1, 1, 1, F,     2'b01, 0, 1);
    add_idle(2, 2'b00, 32'h0, 32'h0, 0);

    repeat (4) begin
      @(posedge clk); @(negedge clk);
      chk("rst2 m_tvalid", m_tvalid2, 0);
      chk("rst2 s_trdy", s_trdy2, 0);
      chk("rst2 grant_id", grant_id2, 0);
      chk("rst2 m_tdata", m_tdata2, 0);
      chk("rst4 m_tvalid", m_tvalid4, 0);
      chk("rst4 s_trdy", s_trdy4, 0);
      chk("rst4 grant_id", grant_id4, 0);
      chk("rst4 grant_active", grant_active4, 0);
    end

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      reset_n   = tbl[i].rst_n;
      s_tvalid2 = tbl[i].vld;
      s_tlast2  = tbl[i].last;
      s_tdata2  = {tbl[i].d1, tbl[i].d0};
      m_trdy2   = tbl[i].trdy;
      s_tvalid4 = 4'h0;
      @(negedge clk);
      exp_keep = tbl[i].e_act ? (tbl[i].e_gid ? 32'h7 : 32'hF) : 32'h0;
      chk($sformatf("row%0d m_tvalid", i), m_tvalid2, tbl[i].e_vld);
      chk($sformatf("row%0d m_tlast", i), m_tlast2, tbl[i].e_last);
      chk($sformatf("row%0d m_tdata", i), m_tdata2, tbl[i].e_dat);
      chk($sformatf("row%0d m_tkeep", i), m_tkeep2, exp_keep);
      chk($sformatf("row%0d s_trdy", i), s_trdy2, tbl[i].e_srdy);
      chk($sformatf("row%0d grant_id", i), grant_id2, tbl[i].e_gid);
      chk($sformatf("row%0d grant_active", i), grant_active2, tbl[i].e_act);
    end

    // Four ports, continuous single-beat frames: grants 0,1,2,3,0,1.
    @(posedge clk); #1;
    s_tvalid4 = 4'hF;
    frames = 0;
    idle = 0;
    for (int cyc = 0; cyc < 200 && frames < 6; cyc++) begin
      @(negedge clk);
      if (grant_active4) begin
        chk($sformatf("wrap%0d grant_id", frames), grant_id4, frames % 4);
        chk($sformatf("wrap%0d m_tdata", frames), m_tdata4, 32'h4000_0000 + (frames % 4));
        chk($sformatf("wrap%0d s_trdy", frames), s_trdy4, 32'h1 << (frames % 4));
        chk($sformatf("wrap%0d m_tvalid", frames), m_tvalid4, 1);
        chk($sformatf("wrap%0d idle_before", frames), idle, (frames == 0) ? 1 : G);
        idle = 0;
        frames++;
      end else begin
        idle++;
      end
    end
    if (frames < 6) chk("wrap timeout frames", frames, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_tx_arbiter.md
# axis_tx_arbiter

Frame-granular round-robin arbiter that shares the single MAC TX AXI-Stream input between `NUM_PORTS` upstream requesters. Sits in front of the 10G MAC TX datapath and ahead of the PCS. Locks the grant for a whole frame, from first beat to `tlast`, so frames are never interleaved. Optionally enforces an idle gap between frames.

## Interface
- `DATA_WIDTH`, 32, beat width in bits; `KEEP_WIDTH = DATA_WIDTH/8`.
- `NUM_PORTS`, 2, number of requesters; legal range 2..4.
- `IFG_CYCLES`, 3, idle cycles inserted after each frame; used only with the macro; legal range 1..15.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_axis_tdata`  in  `NUM_PORTS*DATA_WIDTH`  packed per-port data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tkeep`  in  `NUM_PORTS*KEEP_WIDTH`  packed per-port byte enables.
- `s_axis_tvalid`  in  `NUM_PORTS`  per-port valid.
- `s_axis_tlast`  in  `NUM_PORTS`  per-port end of frame.
- `s_axis_trdy`  out  `NUM_PORTS`  per-port ready.
- `m_axis_tdata`  out  `DATA_WIDTH`  data to the MAC.
- `m_axis_tkeep`  out  `KEEP_WIDTH`  byte enables to the MAC.
- `m_axis_tvalid`  out  1  valid to the MAC.
- `m_axis_tlast`  out  1  end of frame to the MAC.
- `m_axis_trdy`  in  1  ready from the MAC.
- `grant_id`  out  `$clog2(NUM_PORTS)`  index of the current or most recent owner.
- `grant_active`  out  1  high while in XFER.

## Operation
- States are IDLE, XFER and GAP; GAP exists only with the macro.
- **IDLE**
  - All `s_axis_trdy` are 0; `m_axis_tvalid` is 0.
  - If any `s_axis_tvalid` is high, choose the first requesting port at or after `rr_ptr`, searching upward and wrapping modulo `NUM_PORTS`.
  - Register the winner into `grant_id` and go to XFER.
- **XFER**
  - `m_axis_tdata`, `tkeep`, `tvalid` and `tlast` are the granted port's inputs, passed through combinationally.
  - `s_axis_trdy[grant_id]` equals `m_axis_trdy`; every other `s_axis_trdy` bit is 0.
  - The grant holds while the owner deasserts `tvalid` mid-frame; no timeout.
  - On a beat with `m_axis_tvalid & m_axis_trdy & m_axis_tlast`:
    - set `rr_ptr <= (grant_id+1) mod NUM_PORTS`;
    - go to GAP if the macro is defined, otherwise to IDLE.
- **GAP**
  - All outputs are as in IDLE.
  - A 4-bit counter loads `IFG_CYCLES-1` on entry and decrements each cycle; at 0, go to IDLE.
- Requests from non-owners are ignored until re-arbitration; their `tvalid` stays asserted per AXI rules.
- Outside XFER, `m_axis_tdata`, `tkeep` and `tlast` are driven to 0.

## Timing
- **Reset values:** state IDLE, `rr_ptr` 0, `grant_id` 0, `grant_active` 0, `s_axis_trdy` all 0, all `m_axis_*` outputs 0, gap counter 0.
- **Reset mid-frame:** the frame is abandoned. The next cycle is IDLE with outputs as above, and the truncated frame is not resumed.
- **Grant latency:** a request seen in IDLE at edge N gives XFER from cycle N+1, so the first beat can transfer in cycle N+1.
- **Data path:** zero-cycle combinational path from the owner to `m_axis` in XFER.
- **Frame overhead:** each frame costs 1 arbitration cycle, plus `IFG_CYCLES` with the macro. This also applies to back-to-back frames from the same port.
- **Single-beat frames:** `tlast` on the first beat is legal; XFER lasts exactly one cycle when `m_axis_trdy` is high.
- **Simultaneous requests:** all ports requesting with `rr_ptr`=k grants k; the next frame goes to k+1.
- **Wrap-around:** the owner `NUM_PORTS-1` sets `rr_ptr` to 0.
- **Fairness bound:** a continuously requesting port waits at most `NUM_PORTS-1` frames.

## Configuration
- `AXIS_TX_ARB_IFG_EN`
  - **Defined:** GAP state and gap counter are compiled in, and `IFG_CYCLES` idle cycles follow every `tlast` handshake.
  - **Undefined:** GAP and the counter are absent, and XFER goes straight to IDLE after `tlast`.

## Test plan
- **Reset check:** hold `reset_n`=0 for 4 cycles with all `s_axis_tvalid`=1 → `m_axis_tvalid`=0, `s_axis_trdy`=0, `grant_id`=0 throughout.
- **Two-port contention:** `NUM_PORTS`=2, both ports present a 4-beat frame at once, `m_axis_trdy`=1.
  - Port 0's 4 beats are output first, then port 1's 4 beats.
  - Beats are never interleaved, and `grant_id` goes 0→1.
- **Owner stall and back-pressure:** port 0 drops `tvalid` for 3 cycles mid-frame while port 1 requests → grant stays with port 0 until its `tlast`.
  - With `m_axis_trdy` held 0 for 2 cycles, `s_axis_trdy[0]`=0 on those cycles and the data is held stable.
- **Wrap-around with 4 ports:** `NUM_PORTS`=4, all ports request 1-beat frames continuously → grant order 0,1,2,3,0,1.
- **IFG with the macro:** macro defined, `IFG_CYCLES`=3, port 0 sends back-to-back 2-beat frames → exactly 3 GAP cycles plus 1 IDLE cycle with `m_axis_tvalid`=0 between frames.
  - Without the macro, exactly 1 idle cycle.
- **Reset mid-frame:** assert reset on beat 2 of a 5-beat frame from port 1 → next cycle IDLE with all outputs 0.
  - After reset release, the first grant goes to port 0 if requesting (`rr_ptr`=0).
